// File: rtl/traffic_lamp_decoder.sv
// ============================================================================
//  Module      : traffic_lamp_decoder
//  Description : Receives the 2-bit traffic-light code bus (00 off, 01 red,
//                10 green, 11 yellow), brings it into the clk domain through a
//                two-flop synchroniser plus a history flop, accepts a code only
//                once it has been seen on two consecutive synchronised
//                samples, and decodes the accepted code into lamp drives and a
//                pedestrian walk signal. Illegal code transitions or an
//                overlong dwell on a non-off code force a blinking-yellow
//                FAULT mode.
//  Revision    : 1.0 - initial release
//
//  Ports
//    clk           in   system clock
//    reset_n       in   asynchronous active-low reset
//    i_tick        in   one-clk pulse per second, synchronous to clk
//    i_light_code  in   [1:0] code from the sequencer, asynchronous to clk
//    o_lamp_red    out  red lamp drive
//    o_lamp_yellow out  yellow lamp drive (blinks while in FAULT)
//    o_lamp_green  out  green lamp drive
//    o_walk        out  pedestrian walk lamp
//    o_fault       out  high while in FAULT
//    o_dwell       out  [4:0] ticks since last accepted change, saturates at 31
//
//  Parameters
//    MAX_DWELL   ticks a non-off code may persist before FAULT (<= 30)
//    WALK_TICKS  ticks at the start of red during which walk is asserted
//    BLINK_TICKS ticks per yellow toggle in FAULT (>= 1)
//
//  Build option
//    FAULT_LATCH_EN  when defined, FAULT is sticky and only reset_n exits it;
//                    otherwise acceptance of code 00 returns FAULT to OFF.
// ============================================================================
`default_nettype none

module traffic_lamp_decoder #(
    parameter int MAX_DWELL   = 12,
    parameter int WALK_TICKS  = 8,
    parameter int BLINK_TICKS = 1
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       i_tick,
    input  logic [1:0] i_light_code,
    output logic       o_lamp_red,
    output logic       o_lamp_yellow,
    output logic       o_lamp_green,
    output logic       o_walk,
    output logic       o_fault,
    output logic [4:0] o_dwell
);

    typedef enum logic [1:0] {
        ST_OFF   = 2'd0,
        ST_RUN   = 2'd1,
        ST_FAULT = 2'd2
    } state_t;

    localparam logic [1:0]  c_CODE_OFF    = 2'b00;
    localparam logic [1:0]  c_CODE_RED    = 2'b01;
    localparam logic [1:0]  c_CODE_GREEN  = 2'b10;
    localparam logic [1:0]  c_CODE_YELLOW = 2'b11;
    localparam logic [4:0]  c_DWELL_SAT   = 5'd31;
    localparam logic [4:0]  c_DWELL_LIMIT = 5'(MAX_DWELL);
    // One extra bit so WALK_TICKS of 32 means "walk for the whole red phase".
    localparam logic [5:0]  c_WALK_TICKS  = 6'(WALK_TICKS);
    localparam logic [15:0] c_BLINK_LAST  = 16'(BLINK_TICKS - 1);

    logic [1:0]  r_s1;
    logic [1:0]  r_s2;
    logic [1:0]  r_s3;
    logic [1:0]  r_acc;
    logic [4:0]  r_dwell;
    logic        r_yellow;
    logic [15:0] r_blink_cnt;
    state_t      r_state;
    state_t      w_state_next;

    logic w_accept;
    logic w_legal;
    logic w_timeout;
    logic w_fault_entry;

    // ------------------------------------------------------------------
    // Synchroniser (s1, s2) and history flop (s3)
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_s1 <= 2'b00;
            r_s2 <= 2'b00;
            r_s3 <= 2'b00;
        end else begin
            r_s1 <= i_light_code;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
        end
    end

    // A code is taken only after two identical synchronised samples, which
    // also hides any multi-bit skew on the asynchronous bus.
    assign w_accept = (r_s2 == r_s3) && (r_s2 != r_acc);

    always_comb begin
        w_legal = (r_s2 == c_CODE_OFF);
        case ({r_acc, r_s2})
            {c_CODE_OFF,    c_CODE_RED},
            {c_CODE_RED,    c_CODE_GREEN},
            {c_CODE_GREEN,  c_CODE_YELLOW},
            {c_CODE_YELLOW, c_CODE_RED}:   w_legal = 1'b1;
            default: ;
        endcase
    end

    // Fires on the tick that would take dwell to MAX_DWELL+1. An acceptance
    // on the same edge clears dwell instead, so it suppresses the timeout.
    assign w_timeout = i_tick && !w_accept && (r_acc != c_CODE_OFF) &&
                       (r_dwell == c_DWELL_LIMIT);

    // ------------------------------------------------------------------
    // Accepted code and dwell counter
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_acc   <= 2'b00;
            r_dwell <= 5'd0;
        end else if (w_accept) begin
            r_acc   <= r_s2;
            r_dwell <= 5'd0;
        end else if (i_tick && (r_dwell != c_DWELL_SAT)) begin
            r_dwell <= r_dwell + 5'd1;
        end
    end

    // ------------------------------------------------------------------
    // State machine
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_OFF;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_OFF: begin
                if (w_accept) begin
                    if (r_s2 == c_CODE_RED) begin
                        w_state_next = ST_RUN;
                    end else if (r_s2 != c_CODE_OFF) begin
                        w_state_next = ST_FAULT;
                    end
                end
            end
            ST_RUN: begin
                if (w_accept) begin
                    if (r_s2 == c_CODE_OFF) begin
                        w_state_next = ST_OFF;
                    end else if (!w_legal) begin
                        w_state_next = ST_FAULT;
                    end
                end else if (w_timeout) begin
                    w_state_next = ST_FAULT;
                end
            end
            ST_FAULT: begin
`ifdef FAULT_LATCH_EN
                // Sticky: only reset_n leaves FAULT.
                w_state_next = ST_FAULT;
`else
                if (w_accept && (r_s2 == c_CODE_OFF)) begin
                    w_state_next = ST_OFF;
                end
`endif
            end
            default: w_state_next = ST_OFF;
        endcase
    end

    assign w_fault_entry = (r_state != ST_FAULT) && (w_state_next == ST_FAULT);

    // ------------------------------------------------------------------
    // Fault blinker: yellow starts lit on entry, then toggles after every
    // BLINK_TICKS ticks spent in FAULT.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_yellow    <= 1'b0;
            r_blink_cnt <= 16'd0;
        end else if (w_fault_entry) begin
            r_yellow    <= 1'b1;
            r_blink_cnt <= 16'd0;
        end else if ((r_state == ST_FAULT) && i_tick) begin
            if (r_blink_cnt == c_BLINK_LAST) begin
                r_yellow    <= ~r_yellow;
                r_blink_cnt <= 16'd0;
            end else begin
                r_blink_cnt <= r_blink_cnt + 16'd1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Output decode from registered state only
    // ------------------------------------------------------------------
    always_comb begin
        o_lamp_red    = 1'b0;
        o_lamp_yellow = 1'b0;
        o_lamp_green  = 1'b0;
        o_walk        = 1'b0;
        o_fault       = 1'b0;
        case (r_state)
            ST_RUN: begin
                o_lamp_red    = (r_acc == c_CODE_RED);
                o_lamp_green  = (r_acc == c_CODE_GREEN);
                o_lamp_yellow = (r_acc == c_CODE_YELLOW);
                o_walk        = (r_acc == c_CODE_RED) &&
                                ({1'b0, r_dwell} < c_WALK_TICKS);
            end
            ST_FAULT: begin
                o_fault       = 1'b1;
                o_lamp_yellow = r_yellow;
            end
            default: ;
        endcase
    end

    assign o_dwell = r_dwell;

endmodule

`default_nettype wire

// File: tb/tb_traffic_lamp_decoder.sv
// ============================================================================
//  Module      : tb_traffic_lamp_decoder
//  Description : Self-checking bench for traffic_lamp_decoder. A behavioural
//                model built from the sample history, the transition rules and
//                a tick count since fault entry predicts every output after
//                each clock edge; directed scenarios add literal expectations,
//                followed by a randomized run.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_traffic_lamp_decoder;

    localparam int MAX_DWELL   = 12;
    localparam int WALK_TICKS  = 8;
    localparam int BLINK_TICKS = 1;
`ifdef FAULT_LATCH_EN
    localparam bit LATCH = 1'b1;
`else
    localparam bit LATCH = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       tick = 1'b0;
    logic [1:0] light_code = 2'b11;
    logic       lamp_red;
    logic       lamp_yellow;
    logic       lamp_green;
    logic       walk;
    logic       fault;
    logic [4:0] dwell;

    int n_checks = 0;
    int n_fail   = 0;
    int cycle    = 0;

    traffic_lamp_decoder #(
        .MAX_DWELL   (MAX_DWELL),
        .WALK_TICKS  (WALK_TICKS),
        .BLINK_TICKS (BLINK_TICKS)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .i_tick        (tick),
        .i_light_code  (light_code),
        .o_lamp_red    (lamp_red),
        .o_lamp_yellow (lamp_yellow),
        .o_lamp_green  (lamp_green),
        .o_walk        (walk),
        .o_fault       (fault),
        .o_dwell       (dwell)
    );

    always #5 clk = ~clk;

    // ---------------------------------------------------------------
    // Behavioural model
    // ---------------------------------------------------------------
    int m_mode;         // 0 = off, 1 = running, 2 = fault
    int m_acc;
    int m_dwell;
    int m_fault_ticks;  // ticks spent in fault since entry
    int hist[$];        // codes sampled on the last three edges, oldest first

    task automatic model_reset();
        m_mode = 0; m_acc = 0; m_dwell = 0; m_fault_ticks = 0;
        hist.delete();
        hist.push_back(0); hist.push_back(0); hist.push_back(0);
    endtask

    function automatic bit legal(int a, int b);
        return (b == 0) || (a == 0 && b == 1) || (a == 1 && b == 2) ||
               (a == 2 && b == 3) || (a == 3 && b == 1);
    endfunction

    task automatic model_edge(input int code, input bit t);
        int  cand;
        int  nd;
        bit  acc_ev;
        bit  enter_fault;
        if (!reset_n) begin
            model_reset();
            return;
        end
        // A value is accepted once it has been sampled on two edges, the
        // later of which is two edges back from this one.
        cand   = hist[1];
        acc_ev = (hist[0] == hist[1]) && (hist[1] != m_acc);
        nd     = acc_ev ? 0 : (t ? ((m_dwell < 31) ? m_dwell + 1 : 31) : m_dwell);
        enter_fault = 1'b0;
        case (m_mode)
            0: if (acc_ev) begin
                   if (cand == 1) m_mode = 1;
                   else if (cand != 0) enter_fault = 1'b1;
               end
            1: if (acc_ev) begin
                   if (cand == 0) m_mode = 0;
                   else if (!legal(m_acc, cand)) enter_fault = 1'b1;
               end else if (t && m_acc != 0 && nd == MAX_DWELL + 1) begin
                   enter_fault = 1'b1;
               end
            default: begin
                if (acc_ev && cand == 0 && !LATCH) m_mode = 0;
                else if (t) m_fault_ticks++;
            end
        endcase
        if (enter_fault) begin
            m_mode = 2;
            m_fault_ticks = 0;
        end
        if (acc_ev) m_acc = cand;
        m_dwell = nd;
        void'(hist.pop_front());
        hist.push_back(code);
    endtask

    function automatic logic [9:0] model_out();
        logic r, y, g, w, f;
        r = (m_mode == 1) && (m_acc == 1);
        g = (m_mode == 1) && (m_acc == 2);
        y = ((m_mode == 1) && (m_acc == 3)) ||
            ((m_mode == 2) && (((m_fault_ticks / BLINK_TICKS) % 2) == 0));
        w = r && (m_dwell < WALK_TICKS);
        f = (m_mode == 2);
        return {r, y, g, w, f, 5'(m_dwell)};
    endfunction

    // ---------------------------------------------------------------
    // Checking
    // ---------------------------------------------------------------
    task automatic compare_outputs();
        logic [9:0] got;
        logic [9:0] exp;
        got = {lamp_red, lamp_yellow, lamp_green, walk, fault, dwell};
        exp = model_out();
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL model_cmp cycle %0d r/y/g/w/f/dwell got %b %b %b %b %b %0d expected %b %b %b %b %b %0d",
                     cycle, got[9], got[8], got[7], got[6], got[5], got[4:0],
                     exp[9], exp[8], exp[7], exp[6], exp[5], exp[4:0]);
        end
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s cycle %0d got %0d expected %0d", name, cycle, act, exp);
        end
    endtask

    task automatic step(input logic [1:0] code, input bit t);
        light_code = code;
        tick       = t;
        @(posedge clk);
        model_edge(int'(code), t);
        cycle++;
        #1;
        compare_outputs();
        tick = 1'b0;
    endtask

    task automatic hold(input logic [1:0] code, input int n, input bit t);
        for (int i = 0; i < n; i++) step(code, t);
    endtask

    // Asynchronous reset pulse applied between clock edges.
    task automatic reset_pulse(input logic [1:0] code);
        reset_n = 1'b0;
        #1;
        model_reset();
        compare_outputs();
        step(code, 1'b0);
        reset_n = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog cycle %0d got timeout expected completion", cycle);
        $fatal(1, "watchdog expired");
    end

    initial begin
        model_reset();

        // Reset held with code 11 and tick pulsing.
        for (int i = 0; i < 4; i++) step(2'b11, i[0]);
        chk("rst_fault", int'(fault), 0);
        chk("rst_dwell", int'(dwell), 0);
        chk("rst_yellow", int'(lamp_yellow), 0);
        reset_n = 1'b1;
        hold(2'b11, 3, 1'b0);
        chk("rel_still_off", int'(fault), 0);
        step(2'b11, 1'b0);
        chk("rel_fault_edge3", int'(fault), 1);
        chk("rel_fault_yellow", int'(lamp_yellow), 1);
        step(2'b11, 1'b1);
        chk("fault_blink_toggle", int'(lamp_yellow), 0);

        // Reset during FAULT clears outputs immediately.
        reset_n = 1'b0;
        #1;
        model_reset();
        compare_outputs();
        chk("async_rst_fault", int'(fault), 0);
        step(2'b00, 1'b0);
        reset_n = 1'b1;

        // Normal cycle: 01 -> 10 -> 11 -> 01.
        hold(2'b01, 3, 1'b0);
        chk("red_before_edge3", int'(lamp_red), 0);
        step(2'b01, 1'b1);                      // acceptance coincides with tick
        chk("red_on", int'(lamp_red), 1);
        chk("coincide_dwell", int'(dwell), 0);
        chk("walk_start", int'(walk), 1);
        hold(2'b01, 7, 1'b1);
        chk("walk_tick7", int'(walk), 1);
        step(2'b01, 1'b1);
        chk("walk_tick8", int'(walk), 0);
        chk("dwell_8", int'(dwell), 8);
        step(2'b01, 1'b1);
        hold(2'b10, 3, 1'b0);
        chk("green_before_edge3", int'(lamp_green), 0);
        step(2'b10, 1'b0);
        chk("green_on", int'(lamp_green), 1);
        chk("green_red_off", int'(lamp_red), 0);
        hold(2'b10, 10, 1'b1);
        hold(2'b11, 4, 1'b0);
        chk("yellow_run", int'(lamp_yellow), 1);
        hold(2'b11, 2, 1'b1);
        hold(2'b01, 4, 1'b0);
        chk("cycle_no_fault", int'(fault), 0);
        chk("back_to_red", int'(lamp_red), 1);

        // Illegal transition 01 -> 11.
        hold(2'b11, 4, 1'b0);
        chk("illegal_fault", int'(fault), 1);
        chk("illegal_yellow", int'(lamp_yellow), 1);
        chk("illegal_red_off", int'(lamp_red), 0);
        step(2'b11, 1'b1);
        chk("illegal_blink0", int'(lamp_yellow), 0);
        step(2'b11, 1'b1);
        chk("illegal_blink1", int'(lamp_yellow), 1);
        hold(2'b00, 4, 1'b0);
        chk("fault_exit_on_00", int'(fault), LATCH ? 1 : 0);
        reset_pulse(2'b00);

        // Dwell timeout on green.
        hold(2'b01, 4, 1'b0);
        hold(2'b10, 4, 1'b0);
        hold(2'b10, 12, 1'b1);
        chk("timeout_not_yet", int'(fault), 0);
        chk("dwell_12", int'(dwell), 12);
        step(2'b10, 1'b1);
        chk("timeout_fault", int'(fault), 1);
        chk("timeout_dwell", int'(dwell), 13);
        hold(2'b10, 20, 1'b1);
        chk("dwell_saturate", int'(dwell), 31);
        reset_pulse(2'b00);

        // Glitch rejection: one-clock 10 inside red.
        hold(2'b01, 4, 1'b0);
        hold(2'b01, 3, 1'b1);
        step(2'b10, 1'b0);
        hold(2'b01, 6, 1'b0);
        chk("glitch_red_steady", int'(lamp_red), 1);
        chk("glitch_dwell_kept", int'(dwell), 3);

        // Randomized run.
        begin
            logic [1:0] cur;
            int r;
            cur = 2'b01;
            for (int i = 0; i < 3000; i++) begin
                r = int'($urandom_range(0, 199));
                if (r < 3) begin
                    reset_pulse(cur);
                end else if (r < 13) begin
                    step(2'($urandom_range(0, 3)), 1'b0);  // one-clock glitch
                end else begin
                    if (r < 25) cur = 2'($urandom_range(0, 3));
                    else if (r < 40) cur = (cur == 2'b00) ? 2'b01 :
                                           (cur == 2'b01) ? 2'b10 :
                                           (cur == 2'b10) ? 2'b11 : 2'b01;
                    step(cur, ($urandom_range(0, 2) == 0));
                end
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
